// File: rtl/enable_gen_pkg.sv
// Shared encodings and default sizing for the counter-enable strobe generator.
package enable_gen_pkg;

  // Registered operating mode of the strobe generator.
  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  // Defaults sized for a board clock in the tens of MHz.
  localparam int DEF_DIV_WIDTH = 24;
  localparam int DEF_DB_CYCLES = 20000;
  localparam int DEF_DB_BITS   = 16;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce filter for a raw push-button.
// btn_level changes only after DB_CYCLES consecutive synchronised samples
// disagree with it; btn_rise is a registered one-cycle pulse on each 0->1
// update of btn_level.
module btn_debounce
  import enable_gen_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DB_BITS   = DEF_DB_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic step_btn,
  output logic btn_level,
  output logic btn_rise
);

  localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_CYCLES - 1);

  logic [1:0]         sync_q;
  logic [DB_BITS-1:0] count_q;
  logic               sample;

  assign sample = sync_q[1];

  // Bring the asynchronous button into the clk domain before any use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], step_btn};
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (sample != btn_level) begin
        if (count_q == DB_LAST) begin
          btn_level <= sample;
          btn_rise  <= sample;
          count_q   <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else begin
        count_q <= '0;
      end
    end
  end

endmodule

// File: rtl/enable_pulse_gen.sv
// One-cycle counter_enable strobe for the Counter blocks: free-run at a
// programmable period, or single-step from a debounced push-button.
// halt freezes the divider and blocks every strobe. mode_dbg exposes the
// registered mode for observation.
module enable_pulse_gen
  import enable_gen_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DB_BITS   = DEF_DB_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_mode,
  input  logic                 step_btn,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 halt,
  output logic                 counter_enable,
  output logic                 btn_level,
  output mode_e                mode_dbg
);

  mode_e                mode_q, mode_nx;
  logic [DIV_WIDTH-1:0] div_q, div_nx;
  logic [DIV_WIDTH-1:0] last_tick;
  logic                 ce_nx;
  logic                 btn_rise;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_BITS   (DB_BITS)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .step_btn  (step_btn),
    .btn_level (btn_level),
    .btn_rise  (btn_rise)
  );

  // Terminal divider value; a period of 0 behaves like 1. Compared live so a
  // shrinking div_value wraps promptly instead of counting through the top.
  assign last_tick = (div_value == '0) ? '0 : div_value - 1'b1;

  assign mode_dbg = mode_q;

  // Mode, divider and output strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q         <= MODE_STEP;
      div_q          <= '0;
      counter_enable <= 1'b0;
    end else begin
      mode_q         <= mode_nx;
      div_q          <= div_nx;
      counter_enable <= ce_nx;
    end
  end

  // Next mode, divider and strobe; a mode change always wins over a pending strobe.
  always_comb begin
    mode_nx = mode_q;
    div_nx  = div_q;
    ce_nx   = 1'b0;
    case (mode_q)
      MODE_STEP: begin
        div_nx = '0;
        if (run_mode) begin
          mode_nx = MODE_RUN;
        end else begin
          ce_nx = btn_rise & ~halt;
        end
      end
      MODE_RUN: begin
        if (!run_mode) begin
          mode_nx = MODE_STEP;
          div_nx  = '0;
        end else if (!halt) begin
          if (div_q >= last_tick) begin
            div_nx = '0;
            ce_nx  = 1'b1;
          end else begin
            div_nx = div_q + 1'b1;
          end
        end
      end
      default: begin
        mode_nx = MODE_STEP;
        div_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench for enable_pulse_gen with a short debounce window.
module tb_enable_pulse_gen;
  import enable_gen_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run_mode = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic       halt = 1'b0;
  logic       counter_enable;
  logic       btn_level;
  mode_e      mode_dbg;

  always #5 clk = ~clk;

  enable_pulse_gen #(
    .DIV_WIDTH (8),
    .DB_CYCLES (4),
    .DB_BITS   (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_mode       (run_mode),
    .step_btn       (step_btn),
    .div_value      (div_value),
    .halt           (halt),
    .counter_enable (counter_enable),
    .btn_level      (btn_level),
    .mode_dbg       (mode_dbg)
  );

  // ---------------- vector table ----------------
  typedef struct {
    int         phase;
    int         row;
    logic       run_mode;
    logic       step_btn;
    logic [7:0] div_value;
    logic       halt;
    logic       exp_ce;
    logic       exp_lvl;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];   // {mode, counter_enable, btn_level}
  int         total = 0;
  int         bad = 0;

  function automatic void add(int ph, int row, logic r, logic b, logic [7:0] d,
                              logic h, logic ce, logic lvl);
    vec_t v;
    v.phase = ph; v.row = row; v.run_mode = r; v.step_btn = b;
    v.div_value = d; v.halt = h; v.exp_ce = ce; v.exp_lvl = lvl;
    vecs.push_back(v);
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int ph, int row, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s phase=%0d row=%0d got=%b want=%b", name, ph, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    run_mode = 1'b0; step_btn = 1'b0; div_value = 8'd0; halt = 1'b0;
  endtask

  initial begin
    int         bpat[8];
    logic [2:0] e;

    // Phase 1: clean press held 20 cycles, then release.
    for (int k = 1; k <= 20; k++) add(1, k, 1'b0, 1'b1, 8'd0, 1'b0, (k == 7), (k >= 6));
    for (int j = 1; j <= 10; j++) add(1, 20 + j, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, (j <= 5));
    // Phase 2: bounce 1,1,0,0,1,1,0,0 then held; single strobe after 4 stable samples.
    bpat = '{1, 1, 0, 0, 1, 1, 0, 0};
    for (int k = 1; k <= 8; k++) add(2, k, 1'b0, bpat[k-1][0], 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 9; k <= 20; k++) add(2, k, 1'b0, 1'b1, 8'd0, 1'b0, (k == 15), (k >= 14));
    for (int j = 1; j <= 8; j++) add(2, 20 + j, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, (j <= 5));
    // Phase 3: RUN with P=5 (button press ignored), then P=1 via div_value=0.
    for (int r = 1; r <= 30; r++)
      add(3, r, 1'b1, (r >= 3 && r <= 20), 8'd5, 1'b0,
          (r > 1 && (r - 1) % 5 == 0), (r >= 8 && r <= 25));
    for (int r = 1; r <= 6; r++) add(3, 30 + r, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    // Phase 4: P=10 until divider=6, then P=3 -> immediate wrap, then every 3.
    for (int r = 1; r <= 6; r++) add(4, r, 1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
    for (int r = 7; r <= 16; r++) add(4, r, 1'b1, 1'b0, 8'd3, 1'b0, ((r - 7) % 3 == 0), 1'b0);
    // Phase 5: RUN P=4, halt 8 cycles with a press inside; divider resumes from 2.
    for (int r = 1; r <= 20; r++)
      add(5, r, 1'b1, (r >= 4 && r <= 9), 8'd4, (r >= 3 && r <= 10),
          (r == 12 || r == 16 || r == 20), (r >= 9 && r <= 14));
    // Phase 6: back to STEP; press whose edge lands during halt is dropped.
    for (int r = 1; r <= 22; r++)
      add(6, r, 1'b0, (r >= 3 && r <= 14), 8'd4, (r >= 2 && r <= 12),
          1'b0, (r >= 8 && r <= 19));
    // Phase 7: rise pulse coincides with STEP->RUN; edge dropped, RUN P=2 follows.
    for (int r = 1; r <= 12; r++)
      add(7, r, (r >= 7), 1'b1, 8'd2, 1'b0, (r == 9 || r == 11), (r >= 6));
    // Phase 8: RUN->STEP on a cycle that would otherwise wrap; no strobe.
    for (int j = 1; j <= 8; j++) add(8, j, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, (j <= 5));

    // ---- reset held while inputs toggle ----
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_mode  = 1'($urandom_range(0, 1));
      step_btn  = 1'($urandom_range(0, 1));
      halt      = 1'($urandom_range(0, 1));
      div_value = 8'($urandom_range(0, 255));
      tick();
      check("rst_ce", 0, i, counter_enable, 1'b0);
      check("rst_lvl", 0, i, btn_level, 1'b0);
      check("rst_mode", 0, i, mode_dbg, MODE_STEP);
    end
    drive_idle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_ce", 0, 10 + i, counter_enable, 1'b0);
      check("post_rst_lvl", 0, 10 + i, btn_level, 1'b0);
      check("post_rst_mode", 0, 10 + i, mode_dbg, MODE_STEP);
    end

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      run_mode  = vecs[i].run_mode;
      step_btn  = vecs[i].step_btn;
      div_value = vecs[i].div_value;
      halt      = vecs[i].halt;
      exp_q.push_back({vecs[i].run_mode, vecs[i].exp_ce, vecs[i].exp_lvl});
      tick();
      e = exp_q.pop_front();
      check("ce", vecs[i].phase, vecs[i].row, counter_enable, e[1]);
      check("lvl", vecs[i].phase, vecs[i].row, btn_level, e[0]);
      check("mode", vecs[i].phase, vecs[i].row, mode_dbg, e[2]);
    end

    // ---- asynchronous reset while a strobe is high ----
    drive_idle();
    run_mode = 1'b1;
    tick();
    check("arst_enter_ce", 9, 1, counter_enable, 1'b0);
    tick();
    check("arst_strobe_ce", 9, 2, counter_enable, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_drop_ce", 9, 3, counter_enable, 1'b0);
    check("arst_drop_mode", 9, 3, mode_dbg, MODE_STEP);
    tick();
    check("arst_hold_ce", 9, 4, counter_enable, 1'b0);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
